// File: rtl/alu_unit_pkg.sv
// Shared opcode encodings, widths and result-FIFO entry layout for the ALU slice.
// The ALU_MUL_EN macro selects the pipelined multiplier build.
package alu_unit_pkg;

  localparam int OP_W           = 5;
  localparam int DAT_W          = 32;
  localparam int ROB_BIT        = 4;
  localparam int DEF_RESQ_DEPTH = 4;
  localparam int DEF_MUL_LAT    = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_LUI    = 5'd10,
    OP_AUIPC  = 5'd11,
    OP_JAL    = 5'd12,
    OP_JALR   = 5'd13,
    OP_BEQ    = 5'd14,
    OP_BNE    = 5'd15,
    OP_BLT    = 5'd16,
    OP_BGE    = 5'd17,
    OP_BLTU   = 5'd18,
    OP_BGEU   = 5'd19,
    OP_MUL    = 5'd20,
    OP_MULH   = 5'd21,
    OP_MULHSU = 5'd22,
    OP_MULHU  = 5'd23
  } op_e;

  typedef struct packed {
    logic [ROB_BIT-1:0] q;
    logic [DAT_W-1:0]   v;
    logic               jmp;
    logic [DAT_W-1:0]   tgt;
  } res_t;

  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/alu_unit_mul_pipe.sv
// MUL_LAT-stage multiplier pipe; only built when ALU_MUL_EN is defined.
// Product is formed at entry and carried down the stages with its tag.
`ifdef ALU_MUL_EN
module alu_mul_pipe
  import alu_unit_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [OP_W-1:0]    i_op,
  input  logic [DAT_W-1:0]   i_a,
  input  logic [DAT_W-1:0]   i_b,
  input  logic [ROB_BIT-1:0] i_qd,
  input  logic               i_flush,
  output logic               o_valid,
  output logic [ROB_BIT-1:0] o_qd,
  output logic [DAT_W-1:0]   o_product
);

  logic [2*DAT_W-1:0] w_ea, w_eb, w_prod;
  logic [DAT_W-1:0]   w_res;
  logic [MUL_LAT-1:0] r_v;
  logic [ROB_BIT-1:0] r_q [MUL_LAT];
  logic [DAT_W-1:0]   r_p [MUL_LAT];

  // Extend per signedness, then one 2W-bit multiply serves all variants
  always_comb begin
    w_ea = {{DAT_W{1'b0}}, i_a};
    w_eb = {{DAT_W{1'b0}}, i_b};
    if (i_op == OP_MULH || i_op == OP_MULHSU)
      w_ea = {{DAT_W{i_a[DAT_W-1]}}, i_a};
    if (i_op == OP_MULH)
      w_eb = {{DAT_W{i_b[DAT_W-1]}}, i_b};
    w_prod = w_ea * w_eb;
    w_res  = (i_op == OP_MUL) ? w_prod[DAT_W-1:0]
                              : w_prod[2*DAT_W-1:DAT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
    end else if (i_flush) begin
      r_v <= '0;
    end else begin
      r_v[0] <= i_en;
      for (int i = 1; i < MUL_LAT; i++)
        r_v[i] <= r_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_q[0] <= i_qd;
    r_p[0] <= w_res;
    for (int i = 1; i < MUL_LAT; i++) begin
      r_q[i] <= r_q[i-1];
      r_p[i] <= r_p[i-1];
    end
  end

  assign o_valid   = r_v[MUL_LAT-1];
  assign o_qd      = r_q[MUL_LAT-1];
  assign o_product = r_p[MUL_LAT-1];

endmodule
`endif

// File: rtl/alu_unit.sv
// ALU execute + in-order result FIFO driving the ALU CDB.
// Define ALU_MUL_EN for the pipelined multiplier and dual-write FIFO.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int RESQ_DEPTH = DEF_RESQ_DEPTH
`ifdef ALU_MUL_EN
  , parameter int MUL_LAT  = DEF_MUL_LAT
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_en_i,
  input  logic [OP_W-1:0]    alu_op_i,
  input  logic               alu_ic_i,
  input  logic [ROB_BIT-1:0] alu_qd_i,
  input  logic [DAT_W-1:0]   alu_vs_i,
  input  logic [DAT_W-1:0]   alu_vt_i,
  input  logic [DAT_W-1:0]   alu_imm_i,
  input  logic [DAT_W-1:0]   alu_pc_i,
  input  logic               br_flag_i,
  output logic               cdb_en_o,
  output logic [ROB_BIT-1:0] cdb_q_o,
  output logic [DAT_W-1:0]   cdb_v_o,
  output logic               cdb_jmp_o,
  output logic [DAT_W-1:0]   cdb_tgt_o,
  output logic               alu_ovf_o
);

  localparam int PW = (RESQ_DEPTH > 1) ? $clog2(RESQ_DEPTH) : 1;
  localparam int CW = $clog2(RESQ_DEPTH + 1);

  logic [DAT_W-1:0] w_b, w_v, w_tgt;
  logic [4:0]       w_sh;
  logic             w_jmp, w_take, w_isbr;
  res_t             w_simp, w_head, w_d0;
  logic             w_wr_s, w_req0, w_acc0, w_pop;
  logic [CW-1:0]    w_cnt_pp;

  res_t             r_mem [RESQ_DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(RESQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_b  = alu_ic_i ? alu_vt_i : alu_imm_i;
  assign w_sh = w_b[4:0];

  always_comb begin
    w_v    = '0;
    w_jmp  = 1'b0;
    w_tgt  = '0;
    w_take = 1'b0;
    w_isbr = 1'b0;
    case (alu_op_i)
      OP_ADD:   w_v = alu_vs_i + w_b;
      OP_SUB:   w_v = alu_vs_i - w_b;
      OP_SLL:   w_v = alu_vs_i << w_sh;
      OP_SLT:   w_v = {31'b0, $signed(alu_vs_i) < $signed(w_b)};
      OP_SLTU:  w_v = {31'b0, alu_vs_i < w_b};
      OP_XOR:   w_v = alu_vs_i ^ w_b;
      OP_SRL:   w_v = alu_vs_i >> w_sh;
      OP_SRA:   w_v = $unsigned($signed(alu_vs_i) >>> w_sh);
      OP_OR:    w_v = alu_vs_i | w_b;
      OP_AND:   w_v = alu_vs_i & w_b;
      OP_LUI:   w_v = alu_imm_i;
      OP_AUIPC: w_v = alu_pc_i + alu_imm_i;
      OP_JAL: begin
        w_v   = alu_pc_i + 32'd4;
        w_jmp = 1'b1;
        w_tgt = alu_pc_i + alu_imm_i;
      end
      OP_JALR: begin
        w_v   = alu_pc_i + 32'd4;
        w_jmp = 1'b1;
        w_tgt = (alu_vs_i + alu_imm_i) & ~32'd1;
      end
      OP_BEQ: begin w_isbr = 1'b1; w_take = alu_vs_i == alu_vt_i; end
      OP_BNE: begin w_isbr = 1'b1; w_take = alu_vs_i != alu_vt_i; end
      OP_BLT: begin
        w_isbr = 1'b1;
        w_take = $signed(alu_vs_i) < $signed(alu_vt_i);
      end
      OP_BGE: begin
        w_isbr = 1'b1;
        w_take = $signed(alu_vs_i) >= $signed(alu_vt_i);
      end
      OP_BLTU: begin w_isbr = 1'b1; w_take = alu_vs_i < alu_vt_i; end
      OP_BGEU: begin w_isbr = 1'b1; w_take = alu_vs_i >= alu_vt_i; end
      default: ;
    endcase
    if (w_isbr) begin
      w_jmp = w_take;
      w_tgt = w_take ? alu_pc_i + alu_imm_i : alu_pc_i + 32'd4;
    end
  end

  always_comb begin
    w_simp     = '0;
    w_simp.q   = alu_qd_i;
    w_simp.v   = w_v;
    w_simp.jmp = w_jmp;
    w_simp.tgt = w_tgt;
  end

`ifdef ALU_MUL_EN
  logic               w_mul_v;
  logic [ROB_BIT-1:0] w_mul_q;
  logic [DAT_W-1:0]   w_mul_p;
  res_t               w_d1;
  logic               w_req1, w_acc1;
  logic [PW-1:0]      w_wp1;

  alu_mul_pipe #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_en      (alu_en_i && !br_flag_i && is_mul(alu_op_i)),
    .i_op      (alu_op_i),
    .i_a       (alu_vs_i),
    .i_b       (w_b),
    .i_qd      (alu_qd_i),
    .i_flush   (br_flag_i),
    .o_valid   (w_mul_v),
    .o_qd      (w_mul_q),
    .o_product (w_mul_p)
  );

  assign w_wr_s = alu_en_i && !br_flag_i && !is_mul(alu_op_i);

  // A completing multiply is older than this cycle's simple op
  always_comb begin
    w_d1   = w_simp;
    w_d0   = w_simp;
    w_req0 = w_wr_s;
    w_req1 = 1'b0;
    if (w_mul_v) begin
      w_d0     = '0;
      w_d0.q   = w_mul_q;
      w_d0.v   = w_mul_p;
      w_req0   = 1'b1;
      w_req1   = w_wr_s;
    end
  end
`else
  assign w_wr_s = alu_en_i && !br_flag_i;
  assign w_req0 = w_wr_s;
  assign w_d0   = w_simp;
`endif

  assign w_pop    = (r_cnt != '0);
  assign w_cnt_pp = r_cnt - CW'(w_pop);
  assign w_acc0   = w_req0 && (w_cnt_pp < CW'(RESQ_DEPTH));
`ifdef ALU_MUL_EN
  assign w_acc1   = w_req1 &&
                    ((w_cnt_pp + CW'(w_acc0)) < CW'(RESQ_DEPTH));
  assign w_wp1    = f_inc(r_wp);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (br_flag_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_pop)
        r_rp <= f_inc(r_rp);
`ifdef ALU_MUL_EN
      r_wp  <= w_acc1 ? f_inc(w_wp1) : (w_acc0 ? w_wp1 : r_wp);
      r_cnt <= w_cnt_pp + CW'(w_acc0) + CW'(w_acc1);
      if ((w_req0 && !w_acc0) || (w_req1 && !w_acc1))
        r_ovf <= 1'b1;
`else
      r_wp  <= w_acc0 ? f_inc(r_wp) : r_wp;
      r_cnt <= w_cnt_pp + CW'(w_acc0);
      if (w_req0 && !w_acc0)
        r_ovf <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!br_flag_i) begin
      if (w_acc0)
        r_mem[r_wp] <= w_d0;
`ifdef ALU_MUL_EN
      if (w_acc1)
        r_mem[w_wp1] <= w_d1;
`endif
    end
  end

  assign w_head    = r_mem[r_rp];
  assign cdb_en_o  = w_pop;
  assign cdb_q_o   = w_pop ? w_head.q   : '0;
  assign cdb_v_o   = w_pop ? w_head.v   : '0;
  assign cdb_jmp_o = w_pop ? w_head.jmp : 1'b0;
  assign cdb_tgt_o = w_pop ? w_head.tgt : '0;
  assign alu_ovf_o = r_ovf;

endmodule

// File: tb/tb_alu_unit.sv
// Testbench for alu_unit: directed spec cases plus random issue vs a queue model.
// Compile with ALU_MUL_EN to also exercise the multiplier build.
module tb_alu_unit;
  import alu_unit_pkg::*;

`ifdef ALU_MUL_EN
  localparam bit MULEN = 1'b1;
`else
  localparam bit MULEN = 1'b0;
`endif
  localparam int LAT = DEF_MUL_LAT;

  logic        clk, rst;
  logic        alu_en_i, alu_ic_i, br_flag_i;
  logic [4:0]  alu_op_i;
  logic [3:0]  alu_qd_i;
  logic [31:0] alu_vs_i, alu_vt_i, alu_imm_i, alu_pc_i;
  logic        cdb_en_o, cdb_jmp_o, alu_ovf_o;
  logic [3:0]  cdb_q_o;
  logic [31:0] cdb_v_o, cdb_tgt_o;

  alu_unit dut (
    .clk(clk), .rst(rst),
    .alu_en_i(alu_en_i), .alu_op_i(alu_op_i), .alu_ic_i(alu_ic_i),
    .alu_qd_i(alu_qd_i), .alu_vs_i(alu_vs_i), .alu_vt_i(alu_vt_i),
    .alu_imm_i(alu_imm_i), .alu_pc_i(alu_pc_i), .br_flag_i(br_flag_i),
    .cdb_en_o(cdb_en_o), .cdb_q_o(cdb_q_o), .cdb_v_o(cdb_v_o),
    .cdb_jmp_o(cdb_jmp_o), .cdb_tgt_o(cdb_tgt_o), .alu_ovf_o(alu_ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  q;
    logic [31:0] v;
    logic        jmp;
    logic [31:0] tgt;
  } exp_t;

  exp_t mq[$];
  exp_t pq[$];
  int   pdue[$];
  int   cyc;
  int   n_tests, n_fail;

  function automatic exp_t ref_res(input logic [4:0] op, input logic ic,
                                   input logic [31:0] vs, input logic [31:0] vt,
                                   input logic [31:0] imm, input logic [31:0] pc,
                                   input logic [3:0] q);
    exp_t r;
    logic [31:0] b;
    longint sa, sb, ua, ub;
    bit br, tk;
    b  = ic ? vt : imm;
    sa = longint'($signed(vs));
    sb = longint'($signed(b));
    ua = longint'({32'b0, vs});
    ub = longint'({32'b0, b});
    r.q = q; r.v = 0; r.jmp = 0; r.tgt = 0;
    br = 0; tk = 0;
    case (op)
      OP_ADD:   r.v = 32'(ua + ub);
      OP_SUB:   r.v = 32'(ua - ub);
      OP_SLL:   r.v = 32'(ua << b[4:0]);
      OP_SLT:   r.v = (sa < sb) ? 1 : 0;
      OP_SLTU:  r.v = (ua < ub) ? 1 : 0;
      OP_XOR:   r.v = vs ^ b;
      OP_SRL:   r.v = 32'(ua >> b[4:0]);
      OP_SRA:   r.v = 32'(sa >>> b[4:0]);
      OP_OR:    r.v = vs | b;
      OP_AND:   r.v = vs & b;
      OP_LUI:   r.v = imm;
      OP_AUIPC: r.v = pc + imm;
      OP_JAL:   begin r.v = pc + 4; r.jmp = 1; r.tgt = pc + imm; end
      OP_JALR:  begin r.v = pc + 4; r.jmp = 1; r.tgt = (vs + imm) & 32'hFFFF_FFFE; end
      OP_BEQ:   begin br = 1; tk = (vs == vt); end
      OP_BNE:   begin br = 1; tk = (vs != vt); end
      OP_BLT:   begin br = 1; tk = ($signed(vs) < $signed(vt)); end
      OP_BGE:   begin br = 1; tk = ($signed(vs) >= $signed(vt)); end
      OP_BLTU:  begin br = 1; tk = (vs < vt); end
      OP_BGEU:  begin br = 1; tk = (vs >= vt); end
      OP_MUL:   if (MULEN) r.v = 32'(ua * ub);
      OP_MULH:  if (MULEN) r.v = 32'((sa * sb) >>> 32);
      OP_MULHSU: if (MULEN) r.v = 32'((sa * ub) >>> 32);
      OP_MULHU: if (MULEN) r.v = 32'((ua * ub) >> 32);
      default: ;
    endcase
    if (br) begin
      r.jmp = tk;
      r.tgt = tk ? pc + imm : pc + 4;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs,
                     input logic [69:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [69:0] obs_vec();
    return {cdb_en_o, cdb_q_o, cdb_v_o, cdb_jmp_o, cdb_tgt_o};
  endfunction

  function automatic logic [69:0] exp_vec();
    if (mq.size() == 0) return '0;
    return {1'b1, mq[0].q, mq[0].v, mq[0].jmp, mq[0].tgt};
  endfunction

  // One clock: drive, advance the model across the edge, then compare
  task automatic step(input logic en, input logic [4:0] op, input logic ic,
                      input logic [3:0] qd, input logic [31:0] vs,
                      input logic [31:0] vt, input logic [31:0] imm,
                      input logic [31:0] pc, input logic br);
    exp_t r;
    alu_en_i = en; alu_op_i = op; alu_ic_i = ic; alu_qd_i = qd;
    alu_vs_i = vs; alu_vt_i = vt; alu_imm_i = imm; alu_pc_i = pc;
    br_flag_i = br;
    @(posedge clk);
    cyc++;
    if (mq.size() > 0) void'(mq.pop_front());
    if (br) begin
      mq.delete(); pq.delete(); pdue.delete();
    end else begin
      while (pdue.size() > 0 && pdue[0] == cyc) begin
        mq.push_back(pq.pop_front());
        void'(pdue.pop_front());
      end
      if (en) begin
        r = ref_res(op, ic, vs, vt, imm, pc, qd);
        if (MULEN && op >= OP_MUL) begin
          pq.push_back(r);
          pdue.push_back(cyc + LAT);
        end else begin
          mq.push_back(r);
        end
      end
    end
    #1;
    alu_en_i = 1'b0; br_flag_i = 1'b0;
    chk("model", obs_vec(), exp_vec());
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] vs, vt;
    n_tests = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    alu_en_i = 0; alu_op_i = 0; alu_ic_i = 0; alu_qd_i = 0;
    alu_vs_i = 0; alu_vt_i = 0; alu_imm_i = 0; alu_pc_i = 0;
    br_flag_i = 0;
    #1 chk("reset_cdb", obs_vec(), 70'd0);
    chk("reset_ovf", {69'd0, alu_ovf_o}, 70'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    step(1, OP_ADD, 1, 4'd3, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd0, 0);
    chk("add_en", {69'd0, cdb_en_o}, 70'd1);
    chk("add_q", {66'd0, cdb_q_o}, 70'd3);
    chk("add_v", {38'd0, cdb_v_o}, 70'd4);
    chk("add_jmp", {69'd0, cdb_jmp_o}, 70'd0);
    step(1, OP_SRA, 0, 4'd4, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 0);
    chk("sra_v", {38'd0, cdb_v_o}, {38'd0, 32'hF800_0000});

    step(1, OP_BLT, 1, 4'd5, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 0);
    chk("blt", {cdb_jmp_o, cdb_tgt_o, cdb_v_o}, {1'b1, 32'h120, 32'd0});
    step(1, OP_BGEU, 1, 4'd6, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 0);
    chk("bgeu", {cdb_jmp_o, cdb_tgt_o}, {1'b1, 32'h120});
    step(1, OP_BLTU, 1, 4'd7, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 0);
    chk("bltu", {cdb_jmp_o, cdb_tgt_o}, {1'b0, 32'h104});
    step(1, OP_JALR, 0, 4'd8, 32'h1001, 32'd0, 32'd2, 32'h40, 0);
    chk("jalr", {cdb_jmp_o, cdb_v_o, cdb_tgt_o}, {1'b1, 32'h44, 32'h1002});
    idle();
    chk("drain_en", {69'd0, cdb_en_o}, 70'd0);

    for (int i = 1; i <= 4; i++) begin
      step(1, OP_ADD, 1, 4'(i), 32'(i), 32'd10, 32'd0, 32'd0, 0);
      chk("b2b_q", {66'd0, cdb_q_o}, 70'(i));
    end

    step(1, OP_XOR, 1, 4'd9, 32'h55, 32'hFF, 32'd0, 32'd0, 0);
    step(1, OP_ADD, 1, 4'd10, 32'd1, 32'd1, 32'd0, 32'd0, 1);
    chk("flush_en", {69'd0, cdb_en_o}, 70'd0);
    idle();
    chk("flush_after", {69'd0, cdb_en_o}, 70'd0);

`ifdef ALU_MUL_EN
    step(1, OP_MUL, 1, 4'd5, 32'd7, 32'd6, 32'd0, 32'd0, 0);
    chk("mul_hidden", {69'd0, cdb_en_o}, 70'd0);
    step(1, OP_ADD, 1, 4'd6, 32'd1, 32'd2, 32'd0, 32'd0, 0);
    chk("add_first", {66'd0, cdb_q_o}, 70'd6);
    repeat (LAT - 2) idle();
    idle();
    chk("mul_res", {cdb_en_o, cdb_q_o, cdb_v_o}, {1'b1, 4'd5, 32'd42});
    step(1, OP_MUL, 1, 4'd7, 32'd3, 32'd4, 32'd0, 32'd0, 0);
    repeat (LAT - 1) idle();
    step(1, OP_ADD, 1, 4'd8, 32'd9, 32'd1, 32'd0, 32'd0, 0);
    chk("coll_mul", {cdb_q_o, cdb_v_o}, {4'd7, 32'd12});
    idle();
    chk("coll_add", {cdb_q_o, cdb_v_o}, {4'd8, 32'd10});
    step(1, OP_MULHU, 1, 4'd9, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 0);
    step(0, OP_ADD, 0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1);
    repeat (LAT + 1) idle();
    chk("mul_flushed", {69'd0, cdb_en_o}, 70'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      op = 5'($urandom_range(0, 23));
      vs = $urandom;
      vt = ($urandom_range(0, 3) == 0) ? vs : $urandom;
      step($urandom_range(0, 3) != 0, op, 1'($urandom), 4'($urandom_range(1, 15)),
           vs, vt, $urandom, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 19) == 0);
    end

    step(1, OP_OR, 1, 4'd11, 32'hF0, 32'h0F, 32'd0, 32'd0, 0);
    step(1, OP_MUL, 1, 4'd12, 32'd2, 32'd3, 32'd0, 32'd0, 0);
    #2 rst = 1'b1;
    #1 chk("rst_mid", obs_vec(), 70'd0);
    @(posedge clk);
    #1 chk("rst_hold", obs_vec(), 70'd0);
    rst = 1'b0;
    mq.delete(); pq.delete(); pdue.delete();
    repeat (LAT + 1) idle();
    chk("rst_lost", {69'd0, cdb_en_o}, 70'd0);
    step(1, OP_SUB, 1, 4'd13, 32'd10, 32'd3, 32'd0, 32'd0, 0);
    chk("post_rst", {cdb_en_o, cdb_q_o, cdb_v_o}, {1'b1, 4'd13, 32'd7});
    chk("ovf", {69'd0, alu_ovf_o}, 70'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
